// File: rtl/sprite_load_router_if.sv
// Loader write stream into the router and BRAM load port out of it.
interface sprite_load_router_if #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned BRAM_AW = 16
);
  logic                pic_switch;
  logic [ADDR_W-1:0]   sdram_base_addr;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_CH-1:0]   load_en;
  logic [BRAM_AW-1:0]  load_addr;
  logic [DATA_W-1:0]   load_data;

  modport master (
    output pic_switch, sdram_base_addr, wr_en, wr_data,
    input  load_en, load_addr, load_data
  );

  modport slave (
    input  pic_switch, sdram_base_addr, wr_en, wr_data,
    output load_en, load_addr, load_data
  );
endinterface

// File: rtl/sprite_load_router.sv
// N-channel sprite capture router: copies loader pixels whose picture base falls in a
// channel's SDRAM window into that channel's BRAM. Optional checksum: SPRITE_LOAD_CHKSUM_EN.
module sprite_load_router #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned BRAM_AW = 16,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = {24'd2552896, 24'd2512896},
  parameter logic [NUM_CH*ADDR_W-1:0] CH_LEN  = {24'd5250, 24'd40000}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_load_router_if.slave  bus,
  output logic                 active,
  output logic [2:0]           cur_ch,
  output logic [NUM_CH-1:0]    ch_done,
  output logic                 all_done,
  output logic                 overflow,
  output logic [NUM_CH*16-1:0] chksum
);
  // Pointer carries one extra bit so it can reach a full 2^BRAM_AW window length.
  localparam int unsigned PW = BRAM_AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cur_ch_q, cur_ch_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_CH-1:0]  load_en_q, load_en_d;
  logic [BRAM_AW-1:0] load_addr_q, load_addr_d;
  logic [DATA_W-1:0]  load_data_q, load_data_d;
  logic [NUM_CH-1:0]  ch_done_q, ch_done_d;
  logic               overflow_q, overflow_d;

  logic               hit;
  logic [2:0]         hit_ch;
  logic [BRAM_AW-1:0] hit_off;
  logic [PW-1:0]      cur_len;
  logic               accept;

  always_comb begin
    hit     = 1'b0;
    hit_ch  = '0;
    hit_off = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!hit &&
          ({1'b0, bus.sdram_base_addr} >= {1'b0, CH_BASE[c*ADDR_W +: ADDR_W]}) &&
          ({1'b0, bus.sdram_base_addr} <  {1'b0, CH_BASE[c*ADDR_W +: ADDR_W]}
                                          + {1'b0, CH_LEN[c*ADDR_W +: ADDR_W]})) begin
        hit     = 1'b1;
        hit_ch  = 3'(c);
        hit_off = BRAM_AW'(bus.sdram_base_addr - CH_BASE[c*ADDR_W +: ADDR_W]);
      end
    end
  end

  always_comb begin
    cur_len = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (cur_ch_q == 3'(c)) cur_len = CH_LEN[c*ADDR_W +: PW];
    end
  end

  assign accept = !bus.pic_switch && (state_q == ACTIVE) && bus.wr_en && (ptr_q < cur_len);

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    ptr_d       = ptr_q;
    load_en_d   = '0;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;
    ch_done_d   = ch_done_q;
    overflow_d  = overflow_q;
    if (bus.pic_switch) begin
      if (hit) begin
        state_d  = ACTIVE;
        cur_ch_d = hit_ch;
        ptr_d    = {1'b0, hit_off};
      end else begin
        state_d  = IDLE;
      end
    end else if (state_q == ACTIVE && bus.wr_en) begin
      if (accept) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (cur_ch_q == 3'(c)) begin
            load_en_d[c] = 1'b1;
            if (ptr_q == cur_len - PW'(1)) ch_done_d[c] = 1'b1;
          end
        end
        load_addr_d = ptr_q[BRAM_AW-1:0];
        load_data_d = bus.wr_data;
        ptr_d       = ptr_q + PW'(1);
      end else begin
        overflow_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_ch_q    <= '0;
      ptr_q       <= '0;
      load_en_q   <= '0;
      load_addr_q <= '0;
      load_data_q <= '0;
      ch_done_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      ptr_q       <= ptr_d;
      load_en_q   <= load_en_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
      ch_done_q   <= ch_done_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef SPRITE_LOAD_CHKSUM_EN
  logic [NUM_CH*16-1:0] chksum_q, chksum_d;

  always_comb begin
    chksum_d = chksum_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.pic_switch && hit && hit_off == '0 && hit_ch == 3'(c)) begin
        chksum_d[c*16 +: 16] = '0;
      end else if (accept && cur_ch_q == 3'(c)) begin
        chksum_d[c*16 +: 16] = {chksum_q[c*16 +: 15], chksum_q[c*16 + 15]} ^ 16'(bus.wr_data);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chksum_q <= '0;
    else        chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`else
  assign chksum = '0;
`endif

  assign bus.load_en   = load_en_q;
  assign bus.load_addr = load_addr_q;
  assign bus.load_data = load_data_q;
  assign active        = (state_q == ACTIVE);
  assign cur_ch        = cur_ch_q;
  assign ch_done       = ch_done_q;
  assign all_done      = &ch_done_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_sprite_load_router.sv
// Directed bench for sprite_load_router: pipe/bird loads, unmatched base, window end,
// pic_switch/wr_en collision, asynchronous reset mid-capture and the optional checksum.
module tb_sprite_load_router;
  logic        clk;
  logic        rst_n;
  logic        active;
  logic [2:0]  cur_ch;
  logic [1:0]  ch_done;
  logic        all_done;
  logic        overflow;
  logic [31:0] chksum;

  int n_cmp = 0;
  int n_err = 0;

  sprite_load_router_if #(.NUM_CH(2), .ADDR_W(24), .DATA_W(16), .BRAM_AW(16)) bus ();

  sprite_load_router #(
    .NUM_CH(2), .ADDR_W(24), .DATA_W(16), .BRAM_AW(16),
    .CH_BASE({24'd2552896, 24'd2512896}),
    .CH_LEN ({24'd5250, 24'd40000})
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .active   (active),
    .cur_ch   (cur_ch),
    .ch_done  (ch_done),
    .all_done (all_done),
    .overflow (overflow),
    .chksum   (chksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 7 + 3);
  endfunction

  task automatic select(input string tag, input logic [23:0] base, input logic exp_act,
                        input logic [2:0] exp_ch);
    @(negedge clk);
    bus.pic_switch      = 1'b1;
    bus.sdram_base_addr = base;
    @(negedge clk);
    bus.pic_switch      = 1'b0;
    check({tag, "_active"}, 64'(active), 64'(exp_act));
    if (exp_act) check({tag, "_cur_ch"}, 64'(cur_ch), 64'(exp_ch));
  endtask

  // Drives n back-to-back writes; write k is checked one cycle after it is driven.
  task automatic burst(input string tag, input int n, input logic [1:0] en, input int addr0,
                       input int n_ok, input int ch, input logic dbefore, input int didx);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        int k;
        k = i - 1;
        if (k < n_ok) begin
          check({tag, "_en"},   64'(bus.load_en),   64'(en));
          check({tag, "_addr"}, 64'(bus.load_addr), 64'(addr0 + k));
          check({tag, "_data"}, 64'(bus.load_data), 64'(pat(addr0 + k)));
        end else begin
          check({tag, "_en_drop"}, 64'(bus.load_en), 64'(0));
        end
        check({tag, "_done"}, 64'((ch_done >> ch) & 2'b01),
              64'((didx >= 0 && k >= didx) ? 1'b1 : dbefore));
      end
      if (i < n) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = pat(addr0 + i);
      end else begin
        bus.wr_en   = 1'b0;
      end
    end
  endtask

  initial begin
    bus.pic_switch      = 1'b0;
    bus.sdram_base_addr = '0;
    bus.wr_en           = 1'b0;
    bus.wr_data         = '0;
    rst_n               = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_en",       64'(bus.load_en),   64'(0));
    check("rst_addr",     64'(bus.load_addr), 64'(0));
    check("rst_active",   64'(active),        64'(0));
    check("rst_done",     64'(ch_done),       64'(0));
    check("rst_overflow", 64'(overflow),      64'(0));
    check("rst_chksum",   64'(chksum),        64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    select("pipe_sel", 24'd2512896, 1'b1, 3'd0);
    burst("pipe", 40000, 2'b01, 0, 40000, 0, 1'b0, 39999);
    check("pipe_done",     64'(ch_done),  64'(2'b01));
    check("pipe_all_done", 64'(all_done), 64'(0));
    check("pipe_overflow", 64'(overflow), 64'(0));

    select("bird0_sel", 24'd2552896, 1'b1, 3'd1);
    burst("bird0", 1750, 2'b10, 0, 1750, 1, 1'b0, -1);
    select("bird1_sel", 24'd2554646, 1'b1, 3'd1);
    burst("bird1", 1750, 2'b10, 1750, 1750, 1, 1'b0, -1);
    select("bird2_sel", 24'd2556396, 1'b1, 3'd1);
    burst("bird2", 1750, 2'b10, 3500, 1750, 1, 1'b0, 1749);
    check("bird_done",     64'(ch_done),  64'(2'b11));
    check("bird_all_done", 64'(all_done), 64'(1));
    check("bird_overflow", 64'(overflow), 64'(0));

    select("nomatch_sel", 24'd786432, 1'b0, 3'd0);
    burst("nomatch", 100, 2'b00, 0, 0, 1, 1'b1, -1);
    check("nomatch_active",   64'(active),   64'(0));
    check("nomatch_overflow", 64'(overflow), 64'(0));

    select("wend_sel", 24'd2556396, 1'b1, 3'd1);
    burst("wend", 1751, 2'b10, 3500, 1750, 1, 1'b1, -1);
    check("wend_overflow", 64'(overflow),      64'(1));
    check("wend_addr",     64'(bus.load_addr), 64'(5249));
    check("wend_active",   64'(active),        64'(1));

    // Collision: the write presented with pic_switch must not reach the BRAM.
    @(negedge clk);
    bus.pic_switch      = 1'b1;
    bus.sdram_base_addr = 24'd2512896;
    bus.wr_en           = 1'b1;
    bus.wr_data         = 16'hDEAD;
    @(negedge clk);
    bus.pic_switch      = 1'b0;
    bus.wr_en           = 1'b0;
    check("coll_en",     64'(bus.load_en), 64'(0));
    check("coll_active", 64'(active),      64'(1));
    check("coll_cur_ch", 64'(cur_ch),      64'(0));
    burst("coll_after", 3, 2'b01, 0, 3, 0, 1'b1, -1);

    // Asynchronous reset in the middle of a write pulse.
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h1234;
    @(posedge clk);
    #2;
    check("mid_en_pre", 64'(bus.load_en), 64'(2'b01));
    rst_n = 1'b0;
    #1;
    check("mrst_en",       64'(bus.load_en),   64'(0));
    check("mrst_addr",     64'(bus.load_addr), 64'(0));
    check("mrst_data",     64'(bus.load_data), 64'(0));
    check("mrst_active",   64'(active),        64'(0));
    check("mrst_cur_ch",   64'(cur_ch),        64'(0));
    check("mrst_done",     64'(ch_done),       64'(0));
    check("mrst_all_done", 64'(all_done),      64'(0));
    check("mrst_overflow", 64'(overflow),      64'(0));
    check("mrst_chksum",   64'(chksum),        64'(0));
    @(negedge clk);
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;

    select("ck_sel", 24'd2512896, 1'b1, 3'd0);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h0001;
    @(negedge clk);
    bus.wr_data = 16'h0002;
`ifdef SPRITE_LOAD_CHKSUM_EN
    check("ck_first", 64'(chksum[15:0]), 64'(16'h0001));
`else
    check("ck_first", 64'(chksum), 64'(0));
`endif
    @(negedge clk);
    bus.wr_en = 1'b0;
`ifdef SPRITE_LOAD_CHKSUM_EN
    check("ck_second", 64'(chksum[15:0]), 64'(16'h0000));
`else
    check("ck_second", 64'(chksum), 64'(0));
`endif
    check("ck_addr", 64'(bus.load_addr), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
